// File: rtl/spi_master_byte_if.sv
// Host-side byte stream of the SPI initiator: tx handshake in, rx pulse and busy out.
// "master" is the host driving bytes in; "slave" is the SPI block.
interface spi_master_byte_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_master_byte.sv
// SPI mode-0 initiator, MSB first, one byte per handshake; tx_last closes the ncs frame.
// Every output is a flop; sdi is captured on the edge that raises sck.
module spi_master_byte #(
  parameter int CLK_DIV  = 6,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_byte_if.slave  bus,
  output logic              spi_sck,
  output logic              spi_sdo,
  input  logic              spi_sdi,
  output logic              spi_ncs
);

  // One counter is shared by every timed state, so size it for the longest one.
  localparam int M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M2   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAXP = (M1 > M2) ? M1 : M2;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      last         <= 1'b0;
      spi_ncs      <= 1'b1;
      spi_sck      <= 1'b0;
      spi_sdo      <= 1'b0;
      bus.tx_ready <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
      bus.busy     <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_valid && bus.tx_ready) begin
            shift        <= bus.tx_data;
            last         <= bus.tx_last;
            spi_ncs      <= 1'b0;
            spi_sdo      <= bus.tx_data[7];
            bus.tx_ready <= 1'b0;
            bus.busy     <= 1'b1;
            cnt          <= '0;
            state        <= SETUP;
          end else begin
            bus.tx_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == CW'(CS_SETUP - 1)) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              shift   <= {shift[6:0], spi_sdi};
            end else begin
              spi_sck <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                // sdo keeps the final bit through HOLD/WAIT.
                bus.rx_data  <= shift;
                bus.rx_valid <= 1'b1;
                bus.tx_ready <= !last;
                state        <= last ? HOLD : WAIT;
              end else begin
                spi_sdo <= shift[7];
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (bus.tx_valid && bus.tx_ready) begin
            shift        <= bus.tx_data;
            last         <= bus.tx_last;
            spi_sdo      <= bus.tx_data[7];
            bus.tx_ready <= 1'b0;
            cnt          <= '0;
            state        <= SHIFT;
          end
        end
        HOLD: begin
          if (cnt == CW'(CS_HOLD - 1)) begin
            cnt     <= '0;
            spi_ncs <= 1'b1;
            spi_sdo <= 1'b0;
            state   <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(CS_GAP - 1)) begin
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.tx_ready <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench: default instance (CLK_DIV=6) plus a fast instance (CLK_DIV=1, CS_SETUP=1),
// each with a small mode-0 responder that can also loop sdo back to sdi.
module tb_spi_master_byte;
  localparam int PER  = 10;
  localparam int HALF = 5;

  logic clk, rst;
  spi_master_byte_if dif ();
  spi_master_byte_if fif ();
  logic sck_d, sdo_d, sdi_d, ncs_d;
  logic sck_f, sdo_f, sdi_f, ncs_f;

  spi_master_byte dut_d (
    .clk(clk), .rst(rst), .bus(dif),
    .spi_sck(sck_d), .spi_sdo(sdo_d), .spi_sdi(sdi_d), .spi_ncs(ncs_d)
  );

  spi_master_byte #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(2), .CS_GAP(4)) dut_f (
    .clk(clk), .rst(rst), .bus(fif),
    .spi_sck(sck_f), .spi_sdo(sdo_f), .spi_sdi(sdi_f), .spi_ncs(ncs_f)
  );

  initial begin
    clk = 1'b0;
    forever #HALF clk = ~clk;
  end

  // responder models and monitors
  logic [7:0] ssr_d, ssr_f, mosi_d, mosi_f;
  bit         loop_d, loop_f;
  int         rises_d, rises_f, stray_d, stray_f, ncs_rise_d, rxv_d, acc_f;
  longint     prev_f, pmin_f, pmax_f, t_acc;

  assign sdi_d = loop_d ? sdo_d : ssr_d[7];
  assign sdi_f = loop_f ? sdo_f : ssr_f[7];

  always @(negedge sck_d) ssr_d = {ssr_d[6:0], 1'b0};
  always @(negedge sck_f) ssr_f = {ssr_f[6:0], 1'b0};

  always @(posedge sck_d) begin
    rises_d = rises_d + 1;
    mosi_d  = {mosi_d[6:0], sdo_d};
    if (ncs_d) stray_d = stray_d + 1;
  end

  always @(posedge sck_f) begin
    rises_f = rises_f + 1;
    mosi_f  = {mosi_f[6:0], sdo_f};
    if (ncs_f) stray_f = stray_f + 1;
    if (prev_f >= 0) begin
      if ($time - prev_f < pmin_f) pmin_f = $time - prev_f;
      if ($time - prev_f > pmax_f) pmax_f = $time - prev_f;
    end
    prev_f = $time;
  end

  always @(posedge ncs_d) ncs_rise_d = ncs_rise_d + 1;

  always @(posedge clk) begin
    if (dif.rx_valid) rxv_d = rxv_d + 1;
    if (fif.tx_valid && fif.tx_ready) acc_f = acc_f + 1;
  end

  int nchk, nerr;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic bit rdy(input bit f);
    return f ? fif.tx_ready : dif.tx_ready;
  endfunction

  // Present a byte, wait for the handshake; t_acc marks the accepting edge.
  task automatic start(input bit f, input logic [7:0] d, input bit lst,
                       input logic [7:0] resp, input bit lp, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    if (f) begin
      ssr_f = resp; loop_f = lp;
      fif.tx_valid = 1'b1; fif.tx_data = d; fif.tx_last = lst;
    end else begin
      ssr_d = resp; loop_d = lp;
      dif.tx_valid = 1'b1; dif.tx_data = d; dif.tx_last = lst;
    end
    while (!rdy(f) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout("handshake");
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    if (!keep) begin
      if (f) fif.tx_valid = 1'b0;
      else   dif.tx_valid = 1'b0;
    end
  endtask

  // Returns at the negedge where rx_valid is seen; lat counts clk edges since accept.
  task automatic wait_rx(input bit f, output int lat, output int rx);
    int n;
    n = 0;
    while (!(f ? fif.rx_valid : dif.rx_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      timeout("rx_valid");
      lat = -1;
      rx  = -1;
    end else begin
      lat = int'(($time - HALF - t_acc) / PER);
      rx  = int'(f ? fif.rx_data : dif.rx_data);
    end
  endtask

  // After a last byte: check ncs hold of 2 cycles and 6 cycles until tx_ready returns.
  task automatic check_close(input string tag);
    int n;
    @(negedge clk);
    chk({tag, "_rxv_pulse"}, int'(dif.rx_valid), 0);
    chk({tag, "_ncs_hold"}, int'(ncs_d), 0);
    @(negedge clk);
    chk({tag, "_ncs_rel"}, int'(ncs_d), 1);
    chk({tag, "_sdo_idle"}, int'(sdo_d), 0);
    n = 2;
    while (!dif.tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_gap"}, n, 6);
    chk({tag, "_busy_idle"}, int'(dif.busy), 0);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] resp;
    bit         lp;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t tbl[4];
  int lat, rx, viol, rxv0, n;

  initial begin
    tbl[0] = '{tx: 8'hA5, resp: 8'h00, lp: 1'b1, exp_rx: 8'hA5, exp_mosi: 8'hA5};
    tbl[1] = '{tx: 8'h81, resp: 8'h3C, lp: 1'b0, exp_rx: 8'h3C, exp_mosi: 8'h81};
    tbl[2] = '{tx: 8'h00, resp: 8'hFF, lp: 1'b0, exp_rx: 8'hFF, exp_mosi: 8'h00};
    tbl[3] = '{tx: 8'hFF, resp: 8'h00, lp: 1'b0, exp_rx: 8'h00, exp_mosi: 8'hFF};

    nchk = 0; nerr = 0;
    rises_d = 0; rises_f = 0; stray_d = 0; stray_f = 0; ncs_rise_d = 0; rxv_d = 0; acc_f = 0;
    prev_f = -1; pmin_f = 1000; pmax_f = 0; t_acc = 0;
    ssr_d = '0; ssr_f = '0; mosi_d = '0; mosi_f = '0; loop_d = 1'b0; loop_f = 1'b0;
    dif.tx_valid = 1'b0; dif.tx_data = '0; dif.tx_last = 1'b0;
    fif.tx_valid = 1'b0; fif.tx_data = '0; fif.tx_last = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ncs", int'(ncs_d), 1);
    chk("rst_sck", int'(sck_d), 0);
    chk("rst_sdo", int'(sdo_d), 0);
    chk("rst_tx_ready", int'(dif.tx_ready), 0);
    chk("rst_rx_valid", int'(dif.rx_valid), 0);
    chk("rst_rx_data", int'(dif.rx_data), 0);
    chk("rst_busy", int'(dif.busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx_ready", int'(dif.tx_ready), 1);

    // single-byte frames
    for (int i = 0; i < 4; i++) begin
      rises_d = 0;
      start(1'b0, tbl[i].tx, 1'b1, tbl[i].resp, tbl[i].lp, 1'b0);
      chk("busy_active", int'(dif.busy), 1);
      wait_rx(1'b0, lat, rx);
      chk("vec_rx_data", rx, int'(tbl[i].exp_rx));
      chk("vec_latency", lat, 98);
      chk("vec_sck_rises", rises_d, 8);
      chk("vec_mosi", int'(mosi_d), int'(tbl[i].exp_mosi));
      chk("vec_ncs_at_rx", int'(ncs_d), 0);
      check_close("vec");
    end

    // two-byte frame with a 50-cycle stall in WAIT
    rises_d = 0; ncs_rise_d = 0;
    start(1'b0, 8'h12, 1'b0, 8'h5A, 1'b0, 1'b0);
    wait_rx(1'b0, lat, rx);
    chk("f1_rx_data", rx, 'h5A);
    chk("f1_latency", lat, 98);
    chk("f1_mosi", int'(mosi_d), 'h12);
    chk("f1_wait_ready", int'(dif.tx_ready), 1);
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (ncs_d || sck_d || !dif.tx_ready) viol++;
    end
    chk("wait_stall_viol", viol, 0);
    start(1'b0, 8'h34, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_rx(1'b0, lat, rx);
    chk("f2_rx_data", rx, 'h34);
    chk("f2_latency_nosetup", lat, 96);
    chk("f2_mosi", int'(mosi_d), 'h34);
    chk("frame_sck_rises", rises_d, 16);
    chk("frame_ncs_no_rise", ncs_rise_d, 0);
    check_close("frame");

    // reset in the middle of bit 4
    rises_d = 0;
    start(1'b0, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
    n = 0;
    while (rises_d < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("bit4");
    rxv0 = rxv_d;
    rst = 1'b1;
    #1;
    chk("midrst_ncs", int'(ncs_d), 1);
    chk("midrst_sck", int'(sck_d), 0);
    chk("midrst_sdo", int'(sdo_d), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_rxv", rxv_d, rxv0);
    rises_d = 0;
    start(1'b0, 8'h5A, 1'b1, 8'hC3, 1'b0, 1'b0);
    wait_rx(1'b0, lat, rx);
    chk("after_rst_rx", rx, 'hC3);
    chk("after_rst_mosi", int'(mosi_d), 'h5A);
    chk("after_rst_latency", lat, 98);
    chk("after_rst_rises", rises_d, 8);
    check_close("after_rst");

    // fast instance; tx_valid held high through SHIFT/HOLD/GAP must not be taken
    rises_f = 0; acc_f = 0; prev_f = -1; pmin_f = 1000; pmax_f = 0;
    start(1'b1, 8'h96, 1'b1, 8'h00, 1'b1, 1'b1);
    wait_rx(1'b1, lat, rx);
    chk("fast_rx", rx, 'h96);
    chk("fast_latency", lat, 17);
    n = 0;
    while (!fif.tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    fif.tx_valid = 1'b0;
    chk("fast_gap", n, 6);
    @(negedge clk);
    chk("fast_single_accept", acc_f, 1);
    chk("fast_rises", rises_f, 8);
    chk("fast_period_min", int'(pmin_f), 2 * PER);
    chk("fast_period_max", int'(pmax_f), 2 * PER);

    chk("stray_sck_d", stray_d, 0);
    chk("stray_sck_f", stray_f, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
